ps2_scan_rx: RTL and testbench

- PS/2 keyboard receiver. Runs on the system clock and oversamples the asynchronous ps2_clk/ps2_data pins.
- Deserialises 11-bit frames, checks framing and parity, and queues good scan codes in a small first-word-fall-through FIFO.
- Sits directly upstream of the two-digit hex seven-segment decoder. disp_code feeds that decoder's 8-bit input; the FIFO port feeds the consuming logic.

---
 rtl/ps2_scan_rx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx - PS/2 keyboard scan-code receiver.
//
// Oversamples the asynchronous PS/2 clock/data pins on the system clock,
// deserialises 11-bit frames (start, D0..D7 LSB-first, odd parity, stop),
// validates them and queues good scan codes in a first-word-fall-through
// FIFO. The most recent good code is also held on disp_code for the
// seven-segment stage.
//
// Ports:
//   clk        system clock
//   clrn       asynchronous active-low reset
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_data   raw PS/2 data pin (asynchronous)
//   rd_en      pop request, ignored while ready=0
//   data       FIFO head byte, valid while ready=1 (0 when empty)
//   ready      FIFO non-empty
//   overflow   sticky: a good frame was dropped because the FIFO was full
//   frame_err  one-cycle pulse on a bad start, stop or parity bit
//   disp_code  last good scan code received, queued or not
//
// Parameters:
//   FIFO_DEPTH      FIFO entries, power of 2, >= 2
//   TIMEOUT_CYCLES  mid-frame idle limit in clk cycles
//
// Build option:
//   PS2_TIMEOUT_EN  when defined, a partial frame that sees no ps2_clk
//                   falling edge for TIMEOUT_CYCLES clk cycles is discarded
//                   silently. When undefined, a partial frame waits forever
//                   and only clrn recovers it.

module ps2_scan_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] disp_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ps2_scan_rx: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ps2_scan_rx: TIMEOUT_CYCLES must be at least 1");
  end

  // ---------------------------------------------------------------------
  // Pin synchronisers. Index 0 is nearest the pin. Both chains clear to 1
  // so that releasing reset on an idle bus never fakes a falling edge.
  // ---------------------------------------------------------------------
  logic [2:0] kclk_sync;
  logic [1:0] kdat_sync;
  logic       samp;
  logic       din;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      kclk_sync <= 3'b111;
      kdat_sync <= 2'b11;
    end else begin
      kclk_sync <= {kclk_sync[1:0], ps2_clk};
      kdat_sync <= {kdat_sync[0], ps2_data};
    end
  end

  // Older sample high, newer sample low: one-cycle falling-edge strobe.
  assign samp = kclk_sync[2] & ~kclk_sync[1];
  assign din  = kdat_sync[1];

  // ---------------------------------------------------------------------
  // Deserialiser. shreg collects bits 0..9; the stop bit is taken live
  // from din on the frame-end strobe, so no 11th flop is needed.
  // ---------------------------------------------------------------------
  logic [3:0] bit_cnt;
  logic [9:0] shreg;
  logic       frame_end;
  logic       frame_ok;
  logic [7:0] frame_byte;
  logic       timeout_hit;

  assign frame_end  = samp && (bit_cnt == 4'd10);
  assign frame_byte = shreg[8:1];
  assign frame_ok   = ~shreg[0] & din & (^{frame_byte, shreg[9]});

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt <= 4'd0;
      shreg   <= 10'd0;
    end else if (samp) begin
      shreg   <= {din, shreg[9:1]};
      bit_cnt <= frame_end ? 4'd0 : bit_cnt + 4'd1;
    end else if (timeout_hit) begin
      bit_cnt <= 4'd0;
    end
  end

`ifdef PS2_TIMEOUT_EN
  // Idle timer as a down-counter: reloaded on every strobe (and while no
  // frame is in progress), terminal count at zero aborts the frame.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] IDLE_ONE  = TW'(1);

  logic [TW-1:0] idle_left;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      idle_left <= IDLE_LOAD;
    end else if (samp || bit_cnt == 4'd0) begin
      idle_left <= IDLE_LOAD;
    end else if (idle_left != '0) begin
      idle_left <= idle_left - IDLE_ONE;
    end
  end

  assign timeout_hit = (bit_cnt != 4'd0) && (idle_left == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FIFO. Pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_req;
  logic        push;
  logic        drop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop      = rd_en & ~empty;
  assign push_req = frame_end & frame_ok;
  // A pop in the same cycle frees the slot being written, so a full FIFO
  // still accepts the byte in that case.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign ready = ~empty;
  assign data  = empty ? 8'h00 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= frame_byte;
  end

  // ---------------------------------------------------------------------
  // Status and display outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      disp_code <= 8'h00;
    end else begin
      frame_err <= frame_end & ~frame_ok;
      if (push_req) disp_code <= frame_byte;
      // A drop in the same cycle as a pop cannot happen, but set still wins.
      if (drop)     overflow <= 1'b1;
      else if (pop) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
`timescale 1ns/1ps

module tb_ps2_scan_rx;

  localparam int DEPTH = 8;
  localparam int HALF  = 8;
`ifdef PS2_TIMEOUT_EN
  localparam int TOUT = 100;
`else
  localparam int TOUT = 20000;
`endif

  logic       clk;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_en;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;
  logic [7:0] disp_code;

  ps2_scan_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err),
    .disp_code (disp_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] disp_exp = 8'h00;
  logic       ovf_exp  = 1'b0;
  int         err_exp  = 0;
  int         err_seen = 0;
  logic [7:0] last_pop = 8'h00;
  int         pop_cnt  = 0;
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one completed frame, applied at the instant the FIFO would be written.
  task automatic model_frame(input logic [7:0] b, input logic st, input logic par, input logic sp);
    bit ok;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    ok = (st == 1'b0) && (sp == 1'b1) && (((ones + par) % 2) == 1);
    if (ok) begin
      disp_exp = b;
      if (exp_q.size() >= DEPTH) ovf_exp = 1'b1;
      else exp_q.push_back(b);
    end else begin
      err_exp++;
    end
  endtask

  // Monitor: compares every accepted pop against the scoreboard head.
  always @(negedge clk) begin
    if (clrn === 1'b1) begin
      if (frame_err === 1'b1) err_seen++;
      if (rd_en === 1'b1 && ready === 1'b1) begin
        pop_cnt++;
        last_pop = data;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h expected no entry at %0t", data, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("pop_data", {24'd0, data}, {24'd0, mon_exp});
          ovf_exp = 1'b0;
        end
      end
    end
  end

  function automatic logic good_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic st, input logic par, input logic sp,
                            input bit pop_end, input bit lat_chk);
    logic [10:0] bits;
    bits = {sp, par, b, st};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1 ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (2) @(posedge clk);
        #1;
        if (lat_chk) check("lat_not_early", {31'd0, ready}, 32'd0);
        if (pop_end) rd_en = 1'b1;
        @(posedge clk); #1;
        if (pop_end) rd_en = 1'b0;
        model_frame(b, st, par, sp);
        @(posedge clk); #1;
        if (lat_chk) begin
          check("lat_ready", {31'd0, ready}, 32'd1);
          check("lat_data", {24'd0, data}, {24'd0, b});
        end
        repeat (HALF - 4) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      #1 ps2_clk = 1'b1;
    end
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, good_par(b), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 ps2_data = (i == 0) ? 1'b0 : 1'b1;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
  endtask

  task automatic pop_one();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk); #1 rd_en = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    rd_en = 1'b0;
    check("drain_left", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    check("empty_after_drain", {31'd0, ready}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, {24'd0, data}, 32'd0);
    check({tag, "_ready"}, {31'd0, ready}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_disp"}, {24'd0, disp_code}, 32'd0);
  endtask

  bit rand_done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    clrn = 1'b1;
    repeat (4) @(posedge clk);

    // Single valid frame with latency check, then pop.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t1_disp", {24'd0, disp_code}, {24'd0, disp_exp});
    pop_one();
    check("t1_ready_after_pop", {31'd0, ready}, 32'd0);

    // Bad parity.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_frame_err_count", err_seen, err_exp);
    check("t2_ready", {31'd0, ready}, 32'd0);
    check("t2_disp", {24'd0, disp_code}, {24'd0, disp_exp});

    // Fill and overflow.
    for (int i = 1; i <= 9; i++) send_good(8'(i));
    check("t3_overflow_set", {31'd0, overflow}, {31'd0, ovf_exp});
    check("t3_disp", {24'd0, disp_code}, {24'd0, disp_exp});
    check("t3_ready", {31'd0, ready}, 32'd1);
    pop_one();
    check("t3_overflow_clr", {31'd0, overflow}, {31'd0, ovf_exp});
    drain();
    check("t3_last", {24'd0, last_pop}, 32'h08);

    // Full FIFO with a pop on the same edge as the write.
    for (int i = 0; i < 8; i++) send_good(8'h11 + 8'(i));
    check("t4_full_ready", {31'd0, ready}, 32'd1);
    send_frame(8'hF0, 1'b0, good_par(8'hF0), 1'b1, 1'b1, 1'b0);
    check("t4_overflow", {31'd0, overflow}, {31'd0, ovf_exp});
    drain();
    check("t4_last", {24'd0, last_pop}, 32'hF0);

    // Reset mid-frame.
    send_good(8'h33);
    send_good(8'h44);
    send_partial(5);
    @(posedge clk); #1 clrn = 1'b0;
    exp_q.delete();
    disp_exp = 8'h00;
    ovf_exp  = 1'b0;
    @(posedge clk); #1 check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    repeat (2) @(posedge clk);
    send_good(8'h5A);
    check("t5_ready", {31'd0, ready}, 32'd1);
    check("t5_data", {24'd0, data}, 32'h5A);
    check("t5_frame_err_count", err_seen, err_exp);
    drain();

`ifdef PS2_TIMEOUT_EN
    send_partial(6);
    repeat (150) @(posedge clk);
    pop_cnt = 0;
    send_good(8'h29);
    check("t6_frame_err_count", err_seen, err_exp);
    drain();
    check("t6_pops", pop_cnt, 32'd1);
    check("t6_last", {24'd0, last_pop}, 32'h29);
`endif

    // Randomised traffic with concurrent random pops.
    rand_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          int n;
          logic [7:0] b;
          int kind;
          n = 0;
          while (exp_q.size() >= 6 && n < 500) begin
            @(posedge clk);
            n++;
          end
          if (n >= 500) check("rand_space_wait", exp_q.size(), 32'd0);
          b = 8'($urandom);
          kind = $urandom_range(0, 7);
          case (kind)
            0: send_frame(b, 1'b1, good_par(b), 1'b1, 1'b0, 1'b0);
            1: send_frame(b, 1'b0, good_par(b), 1'b0, 1'b0, 1'b0);
            2: send_frame(b, 1'b0, ~good_par(b), 1'b1, 1'b0, 1'b0);
            default: send_good(b);
          endcase
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1 rd_en = ($urandom_range(0, 2) == 0);
        end
        rd_en = 1'b0;
      end
    join
    drain();
    check("rand_overflow", {31'd0, overflow}, 32'd0);
    check("rand_frame_err_count", err_seen, err_exp);
    check("rand_disp", {24'd0, disp_code}, {24'd0, disp_exp});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
